// File: rtl/lights_pkg.sv
// Shared constants and types for the RGB light decoder: channel levels,
// colour code width and the lock FSM encoding.
package lights_pkg;

    localparam logic [7:0] CHAN_OFF = 8'h00;
    localparam logic [7:0] CHAN_ON  = 8'hFF;
    localparam int         COLOUR_W = 3;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // A channel is only meaningful when it is fully off or fully on.
    function automatic logic chan_is_level(input logic [7:0] chan);
        return (chan == CHAN_OFF) || (chan == CHAN_ON);
    endfunction

endpackage

// File: rtl/light_decoder_if.sv
// Bus between the RGB selector/consumer side and the light decoder.
interface light_decoder_if;

    logic [23:0]                     light;
    logic                            sample_en;
    logic [lights_pkg::COLOUR_W-1:0] colour;
    logic                            valid;
    logic                            error;
    logic                            change;
    logic [7:0]                      change_count;

    modport master (
        output light, sample_en,
        input  colour, valid, error, change, change_count
    );

    modport slave (
        input  light, sample_en,
        output colour, valid, error, change, change_count
    );

endinterface

// File: rtl/rgb_classify.sv
// Combinational classifier: maps a 24-bit RGB word onto a 3-bit colour code
// and flags words whose channels are not cleanly off or on.
module rgb_classify
    import lights_pkg::*;
(
    input  logic [23:0]         light,
    output logic [COLOUR_W-1:0] code,
    output logic                invalid
);

    assign code = {light[23:16] == CHAN_ON, light[15:8] == CHAN_ON, light[7:0] == CHAN_ON};

    assign invalid = !(chan_is_level(light[23:16]) &&
                       chan_is_level(light[15:8])  &&
                       chan_is_level(light[7:0]));

endmodule

// File: rtl/light_decoder.sv
// Debounces a sampled RGB word into a committed colour: a colour must be seen
// STABLE_COUNT times in a row to commit, FAULT_LIMIT invalid samples drop lock.
module light_decoder
    import lights_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned FAULT_LIMIT  = 3
) (
    input  logic           clk,
    input  logic           rst,
    light_decoder_if.slave bus
);

    localparam logic [3:0] RUN_MAX   = 4'(STABLE_COUNT);
    localparam logic [3:0] FAULT_MAX = 4'(FAULT_LIMIT);

    logic [23:0]         light_q;
    logic                loaded_q;
    logic [COLOUR_W-1:0] candidate_q, candidate_d;
    logic [3:0]          run_q, run_d;
    logic [3:0]          fault_q, fault_d;
    state_e              state_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                valid_q;
    logic                error_q;
    logic                change_q;
    logic [7:0]          count_q;

    logic [COLOUR_W-1:0] code;
    logic                invalid;
    logic                eval;
    logic                commit;
    logic                drop;

    rgb_classify u_classify (
        .light   (light_q),
        .code    (code),
        .invalid (invalid)
    );

    // loaded_q keeps the cleared capture register from being judged as black.
    assign eval = bus.sample_en && loaded_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        candidate_d = candidate_q;
        run_d       = run_q;
        fault_d     = fault_q;
        if (eval) begin
            if (invalid) begin
                run_d = '0;
                if (fault_q != FAULT_MAX) begin
                    fault_d = fault_q + 4'd1;
                end
            end else begin
                fault_d = '0;
                if (code != candidate_q) begin
                    candidate_d = code;
                    run_d       = 4'd1;
                end else if (run_q != RUN_MAX) begin
                    run_d = run_q + 4'd1;
                end
            end
        end
    end

    // Commit only on the edge the run arrives at RUN_MAX, never while it sits there.
    assign commit = eval && !invalid && (run_d == RUN_MAX) &&
                    ((run_q != RUN_MAX) || (code != candidate_q));
    assign drop   = eval && invalid && (fault_d == FAULT_MAX) && (fault_q != FAULT_MAX);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            light_q     <= '0;
            loaded_q    <= 1'b0;
            candidate_q <= '0;
            run_q       <= '0;
            fault_q     <= '0;
            state_q     <= ST_EMPTY;
            colour_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            change_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            if (bus.sample_en) begin
                light_q  <= bus.light;
                loaded_q <= 1'b1;
            end
            candidate_q <= candidate_d;
            run_q       <= run_d;
            fault_q     <= fault_d;
            error_q     <= eval && invalid;
            change_q    <= 1'b0;

            case (state_q)
                ST_EMPTY: begin
                    if (commit) begin
                        state_q  <= ST_LOCKED;
                        colour_q <= code;
                        valid_q  <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (drop) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end else if (commit && (code != colour_q)) begin
                        colour_q <= code;
                        change_q <= 1'b1;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.colour       = colour_q;
    assign bus.valid        = valid_q;
    assign bus.error        = error_q;
    assign bus.change       = change_q;
    assign bus.change_count = count_q;

endmodule

// File: doc/light_decoder.md
LIGHT_DECODER -- requirements
Module: light_decoder

Interface
REQ-001 Parameter STABLE_COUNT, default 4: number of consecutive matching samples (range 1..15) that must be seen before a colour is committed.
REQ-002 Parameter FAULT_LIMIT, default 3: number of consecutive invalid samples (range 1..15) after which the lock is dropped.
REQ-003 Port clk  input  1: single clock; all flops update on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port light  input  24: RGB word from the selector output, with R=[23:16], G=[15:8], B=[7:0].
REQ-006 Port sample_en  input  1: light is sampled on every edge where this is high.
REQ-007 Port colour  output  3: committed colour code.
REQ-008 Port valid  output  1: high while a committed colour is held.
REQ-009 Port error  output  1: one-cycle pulse for each invalid sample.
REQ-010 Port change  output  1: one-cycle pulse when the committed colour changes from one valid colour to a different one.
REQ-011 Port change_count  output  8: count of change pulses, saturating at 255.

Function
REQ-012 Each channel SHALL be classified as follows: 8'h00 gives bit 0; 8'hFF gives bit 1; any other value makes the sample invalid.
REQ-013 The decoded code SHALL be {R bit, G bit, B bit}, so FFFFFF gives 7, 00FF00 gives 2, and 000000 gives 0.
REQ-014 On an edge with sample_en=1, light SHALL be captured into light_q; the filter SHALL evaluate light_q on the next edge.
REQ-015 Edges with sample_en=0 SHALL neither capture nor evaluate, and SHALL NOT break a run.
REQ-016 Run counter, valid sample with code equal to candidate: run_cnt SHALL increment, saturating at STABLE_COUNT.
REQ-017 Run counter, valid sample with a code different from candidate: candidate SHALL be loaded with the new code and run_cnt SHALL be set to 1.
REQ-018 Run counter, invalid sample: run_cnt SHALL be cleared to 0, error SHALL pulse on that evaluating edge, and fault_cnt SHALL increment.
REQ-019 Any valid sample SHALL clear fault_cnt to 0.
REQ-020 Commit: on the evaluating edge where run_cnt reaches STABLE_COUNT, colour SHALL be loaded with candidate and valid SHALL be set to 1.
REQ-021 With sample_en held high and light constant, valid SHALL rise after exactly STABLE_COUNT+1 edges counted from the first capture edge.
REQ-022 The FSM SHALL have two states, EMPTY (valid=0) and LOCKED (valid=1).
REQ-023 Transition EMPTY to LOCKED SHALL occur on a commit; change SHALL NOT pulse on this transition.
REQ-024 In LOCKED, a commit of a code different from colour SHALL pulse change and increment change_count.
REQ-025 In LOCKED, a commit of the same code as colour SHALL have no visible effect.
REQ-026 A run that continues beyond STABLE_COUNT SHALL NOT re-commit.
REQ-027 Transition LOCKED to EMPTY SHALL occur when fault_cnt reaches FAULT_LIMIT: valid SHALL drop to 0 on that edge, colour SHALL hold its last value, and change SHALL NOT pulse.
REQ-028 After a loss of lock, the next commit SHALL behave as a first lock, with no change pulse.
REQ-029 change_count SHALL stick at 255; change SHALL still pulse while it is saturated.
REQ-030 A new run in progress SHALL leave colour and valid unchanged until that run commits.
REQ-031 change and error SHALL never assert in the same cycle, because they come from mutually exclusive sample classes.

Reset
REQ-032 When rst=1 on an edge, these SHALL be cleared to 0: colour, valid, error, change, change_count, run_cnt, fault_cnt, candidate and light_q; the FSM SHALL enter EMPTY.
REQ-033 rst SHALL take priority over sample_en and any in-progress run; a mid-run reset SHALL discard the partial run.
REQ-034 The first capture after reset SHALL be on the first edge with rst=0 and sample_en=1.

Structure
REQ-035 The shared package lights_pkg SHALL hold: CHAN_OFF=8'h00, CHAN_ON=8'hFF, COLOUR_W=3, and the FSM encodings ST_EMPTY and ST_LOCKED.
REQ-036 One combinational sub-module, rgb_classify, SHALL be used: input 24-bit light; outputs code[2:0] and invalid.
REQ-037 All other logic (capture register, run and fault counters, FSM, output registers) SHALL reside in light_decoder, with all outputs registered.
REQ-038 The expected size of light_decoder is 120-250 lines of RTL.

Verification
REQ-039 Lock: reset, then light=0000FF with sample_en=1 continuous -> valid=1 and colour=1 after exactly 5 edges; change=0; change_count=0.
REQ-040 Change: locked on 1, then light=FFFF00 for 4 samples -> colour=6, one change pulse, change_count=1; with only 3 samples -> colour remains 1.
REQ-041 Fault: locked on 7, then light=123456 for 3 samples -> error pulses 3 times; valid drops on the 3rd evaluating edge; colour stays 7.
REQ-042 Gaps: light=00FF00 with sample_en pattern 1,0,1,0,1,0,1 -> commit to colour=2 on the evaluating edge of the 4th sample.
REQ-043 Saturation: 300 alternating commits between 0 and 7 -> change_count=255, with change still pulsing each time.
REQ-044 Reset mid-run: rst asserted after 2 matching samples -> all outputs 0; the following run needs a full 4 samples to commit.
